// File: rtl/rc5_crypt_core_pkg.sv
// Shared definitions for the RC5 encrypt/decrypt core: FSM encoding,
// RC5 magic constants per word width, and a constant-foldable clog2.
package rc5_crypt_core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [15:0] P16 = 16'hB7E1;
    localparam logic [15:0] Q16 = 16'h9E37;
    localparam logic [31:0] P32 = 32'hB7E15163;
    localparam logic [31:0] Q32 = 32'h9E3779B9;
    localparam logic [63:0] P64 = 64'hB7E151628AED2A6B;
    localparam logic [63:0] Q64 = 64'h9E3779B97F4A7C15;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((r < 32) && ((32'd1 << r) < v)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rc5_crypt_core_round.sv
// Combinational RC5 round: one full encrypt round or one full decrypt round
// (with optional output whitening removal on the final decrypt round).
module rc5_round
    import rc5_crypt_core_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         mode,
    input  logic         fin,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] s_a,
    input  logic [W-1:0] s_b,
    input  logic [W-1:0] s_0,
    input  logic [W-1:0] s_1,
    output logic [W-1:0] a_nxt,
    output logic [W-1:0] b_nxt
);
    localparam int unsigned LGW = clog2(W);

    // Rotations via a doubled word, so a zero amount is naturally identity
    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LGW-1:0] n);
        logic [2*W-1:0] t;
        t = {x, x} << n;
        return t[2*W-1:W];
    endfunction

    function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [LGW-1:0] n);
        logic [2*W-1:0] t;
        t = {x, x} >> n;
        return t[W-1:0];
    endfunction

    logic [W-1:0] ea, eb, da, db;

    // Both directions computed in parallel; mode selects the registered result
    always_comb begin
        ea = rotl(a ^ b, b[LGW-1:0]) + s_a;
        eb = rotl(b ^ ea, ea[LGW-1:0]) + s_b;
        db = rotr(b - s_b, a[LGW-1:0]) ^ a;
        da = rotr(a - s_a, db[LGW-1:0]) ^ db;
        if (mode) begin
            a_nxt = fin ? (da - s_0) : da;
            b_nxt = fin ? (db - s_1) : db;
        end else begin
            a_nxt = ea;
            b_nxt = eb;
        end
    end

endmodule

// File: rtl/rc5_crypt_core.sv
// Iterative RC5 core: accepts one block, runs ROUNDS round edges through a
// single rc5_round instance, then holds the result until it is taken.
module rc5_crypt_core
    import rc5_crypt_core_pkg::*;
#(
    parameter int unsigned W      = 32,
    parameter int unsigned ROUNDS = 12
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      mode,
    input  logic                      di_vld,
    output logic                      di_rdy,
    input  logic [2*W-1:0]            din,
    input  logic [(2*ROUNDS+2)*W-1:0] skey,
    output logic                      do_vld,
    input  logic                      do_rdy,
    output logic [2*W-1:0]            dout,
    output logic                      busy
);
    localparam int unsigned NKEY = 2 * ROUNDS + 2;
    localparam int unsigned KW   = clog2(NKEY);
    localparam int unsigned IW   = clog2(ROUNDS + 2);
    localparam logic [IW-1:0] I_ONE  = IW'(1);
    localparam logic [IW-1:0] I_LAST = IW'(ROUNDS);

    state_t        state, state_n;
    logic [IW-1:0] i, i_n;
    logic [W-1:0]  a, a_n, b, b_n;
    logic          mode_q, mode_n;
    logic [W-1:0]  keys [NKEY];
    logic [KW-1:0] k_a, k_b;
    logic [W-1:0]  r_a, r_b;
    logic          last;

    // View the flat key bus as an indexable word array
    always_comb begin
        for (int unsigned k = 0; k < NKEY; k++) begin
            keys[k] = skey[k*W +: W];
        end
    end

    assign k_a  = KW'({i, 1'b0});
    assign k_b  = {k_a[KW-1:1], 1'b1};
    assign last = mode_q ? (i == I_ONE) : (i == I_LAST);
    assign dout = {a, b};

    rc5_round #(
        .W(W)
    ) u_round (
        .mode  (mode_q),
        .fin   (last),
        .a     (a),
        .b     (b),
        .s_a   (keys[k_a]),
        .s_b   (keys[k_b]),
        .s_0   (keys[0]),
        .s_1   (keys[1]),
        .a_nxt (r_a),
        .b_nxt (r_b)
    );

    // State and datapath registers with synchronous clear
    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= ST_IDLE;
            i      <= '0;
            a      <= '0;
            b      <= '0;
            mode_q <= 1'b0;
        end else begin
            state  <= state_n;
            i      <= i_n;
            a      <= a_n;
            b      <= b_n;
            mode_q <= mode_n;
        end
    end

    // Next-state, datapath load and handshake outputs
    always_comb begin
        state_n = state;
        i_n     = i;
        a_n     = a;
        b_n     = b;
        mode_n  = mode_q;
        di_rdy  = 1'b0;
        do_vld  = 1'b0;
        busy    = 1'b0;
        case (state)
            ST_IDLE: begin
                di_rdy = 1'b1;
                if (di_vld) begin
                    mode_n  = mode;
                    state_n = ST_ROUND;
                    i_n     = mode ? I_LAST : I_ONE;
                    a_n     = mode ? din[2*W-1:W] : (din[2*W-1:W] + keys[0]);
                    b_n     = mode ? din[W-1:0]   : (din[W-1:0]   + keys[1]);
                end
            end
            ST_ROUND: begin
                busy = 1'b1;
                a_n  = r_a;
                b_n  = r_b;
                i_n  = mode_q ? (i - I_ONE) : (i + I_ONE);
                if (last) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                busy   = 1'b1;
                do_vld = 1'b1;
                if (do_rdy) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rc5_crypt_core.sv
// Bench for rc5_crypt_core: W=32 with ROUNDS=1 and ROUNDS=12 instances,
// checked against a loop-based RC5 reference model.
module tb_rc5_crypt_core;

    logic clk = 1'b0;
    logic clr, mode, do_rdy;
    logic [63:0] din;
    logic vld1, vld12;
    logic rdy1, rdy12, ov1, ov12, busy1, busy12;
    logic [63:0] dout1, dout12;
    logic [4*32-1:0]  skey1;
    logic [26*32-1:0] skey12;

    logic [31:0] key_tab [26];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rc5_crypt_core #(.W(32), .ROUNDS(1)) u_dut1 (
        .clk(clk), .clr(clr), .mode(mode), .di_vld(vld1), .di_rdy(rdy1),
        .din(din), .skey(skey1), .do_vld(ov1), .do_rdy(do_rdy),
        .dout(dout1), .busy(busy1)
    );

    rc5_crypt_core #(.W(32), .ROUNDS(12)) u_dut12 (
        .clk(clk), .clr(clr), .mode(mode), .di_vld(vld12), .di_rdy(rdy12),
        .din(din), .skey(skey12), .do_vld(ov12), .do_rdy(do_rdy),
        .dout(dout12), .busy(busy12)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [31:0] n);
        int unsigned m;
        m = n % 32;
        if (m == 0) return x;
        return (x << m) | (x >> (32 - m));
    endfunction

    function automatic logic [31:0] rotr32(input logic [31:0] x, input logic [31:0] n);
        int unsigned m;
        m = n % 32;
        if (m == 0) return x;
        return (x >> m) | (x << (32 - m));
    endfunction

    function automatic logic [63:0] ref_enc(input logic [63:0] blk, input int r);
        logic [31:0] x, y;
        x = blk[63:32] + key_tab[0];
        y = blk[31:0] + key_tab[1];
        for (int k = 1; k <= r; k++) begin
            x = rotl32(x ^ y, y) + key_tab[2*k];
            y = rotl32(y ^ x, x) + key_tab[2*k+1];
        end
        return {x, y};
    endfunction

    function automatic logic [63:0] ref_dec(input logic [63:0] blk, input int r);
        logic [31:0] x, y;
        x = blk[63:32];
        y = blk[31:0];
        for (int k = r; k >= 1; k--) begin
            y = rotr32(y - key_tab[2*k+1], x) ^ x;
            x = rotr32(x - key_tab[2*k], y) ^ y;
        end
        return {x - key_tab[0], y - key_tab[1]};
    endfunction

    task automatic pack_keys();
        for (int k = 0; k < 26; k++) skey12[k*32 +: 32] = key_tab[k];
        for (int k = 0; k < 4; k++)  skey1[k*32 +: 32]  = key_tab[k];
    endtask

    // Standard RC5-32/12 key schedule for an all-zero 16-byte key
    task automatic expand_zero_key();
        logic [31:0] l [4];
        logic [31:0] x, y;
        int ii, jj;
        for (int k = 0; k < 4; k++) l[k] = '0;
        key_tab[0] = 32'hB7E15163;
        for (int k = 1; k < 26; k++) key_tab[k] = key_tab[k-1] + 32'h9E3779B9;
        x = '0; y = '0; ii = 0; jj = 0;
        for (int k = 0; k < 78; k++) begin
            x = rotl32(key_tab[ii] + x + y, 3);
            key_tab[ii] = x;
            y = rotl32(l[jj] + x + y, x + y);
            l[jj] = y;
            ii = (ii + 1) % 26;
            jj = (jj + 1) % 4;
        end
    endtask

    task automatic xfer(input bit big, input logic m, input logic [63:0] blk,
                        output logic [63:0] res);
        bit ok;
        int n;
        ok = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if ((big ? rdy12 : rdy1) === 1'b1) begin ok = 1; break; end
        end
        chk("rdy_wait", 64'(ok), 64'd1);
        mode = m; din = blk;
        if (big) vld12 = 1'b1; else vld1 = 1'b1;
        @(posedge clk); #1;
        vld1 = 1'b0; vld12 = 1'b0;
        chk("busy_after_accept", 64'(big ? busy12 : busy1), 64'd1);
        n = 0;
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk); #1;
            if ((big ? ov12 : ov1) === 1'b1) begin n = c; break; end
        end
        chk("latency", 64'(n), big ? 64'd12 : 64'd1);
        res = big ? dout12 : dout1;
        @(negedge clk); do_rdy = 1'b1;
        @(posedge clk); #1; do_rdy = 1'b0;
        chk("idle_after_hs", 64'(big ? rdy12 : rdy1), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] res, res2, blk_a, blk_b, held;
        bit seen, m;
        int n;

        clr = 1'b1; mode = 1'b0; din = '0; vld1 = 1'b0; vld12 = 1'b0; do_rdy = 1'b0;
        for (int k = 0; k < 26; k++) key_tab[k] = '0;
        pack_keys();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout12", dout12, 64'd0);
        chk("rst_dout1", dout1, 64'd0);
        chk("rst_vld12", 64'(ov12), 64'd0);
        chk("rst_busy12", 64'(busy12), 64'd0);
        @(negedge clk); clr = 1'b0;
        @(posedge clk); #1;
        chk("rst_rdy12", 64'(rdy12), 64'd1);
        chk("rst_rdy1", 64'(rdy1), 64'd1);

        // Single-round vectors with all-zero keys
        xfer(1'b0, 1'b0, 64'h00000001_00000000, res);
        chk("r1_enc", res, 64'h00000001_00000002);
        xfer(1'b0, 1'b1, 64'h00000001_00000002, res);
        chk("r1_dec", res, 64'h00000001_00000000);
        xfer(1'b0, 1'b0, 64'h80000000_80000000, res);
        chk("r1_rot0", res, 64'h00000000_80000000);

        // Reference vector: zero key, zero plaintext, 12 rounds
        expand_zero_key();
        pack_keys();
        xfer(1'b1, 1'b0, 64'd0, res);
        chk("r12_vec", res, 64'hEEDBA521_6D8F4B15);
        chk("r12_vec_model", res, ref_enc(64'd0, 12));
        xfer(1'b1, 1'b1, res, res2);
        chk("r12_vec_dec", res2, 64'd0);

        // Output back-pressure with di_vld held high
        blk_a = {$urandom, $urandom};
        blk_b = {$urandom, $urandom};
        @(negedge clk);
        mode = 1'b0; din = blk_a; vld12 = 1'b1;
        @(posedge clk); #1;
        din = blk_b;
        seen = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (ov12 === 1'b1) begin seen = 1; break; end
        end
        chk("bp_vld_rise", 64'(seen), 64'd1);
        held = dout12;
        chk("bp_result", held, ref_enc(blk_a, 12));
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp_dout_stable", dout12, held);
            chk("bp_vld_held", 64'(ov12), 64'd1);
            chk("bp_rdy_low", 64'(rdy12), 64'd0);
        end
        @(negedge clk); do_rdy = 1'b1;
        @(posedge clk); #1; do_rdy = 1'b0;
        chk("bp_hs_rdy", 64'(rdy12), 64'd1);
        chk("bp_hs_busy", 64'(busy12), 64'd0);
        chk("bp_hs_vld", 64'(ov12), 64'd0);
        @(posedge clk); #1;
        vld12 = 1'b0;
        chk("bp_next_accept", 64'(busy12), 64'd1);
        n = 0;
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk); #1;
            if (ov12 === 1'b1) begin n = c; break; end
        end
        chk("bp_b_latency", 64'(n), 64'd12);
        chk("bp_b_result", dout12, ref_enc(blk_b, 12));
        @(negedge clk); do_rdy = 1'b1;
        @(posedge clk); #1; do_rdy = 1'b0;

        // Clear in the middle of a 12-round encrypt
        @(negedge clk);
        mode = 1'b0; din = {$urandom, $urandom}; vld12 = 1'b1;
        @(posedge clk); #1;
        vld12 = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); clr = 1'b1;
        @(posedge clk); #1; clr = 1'b0;
        chk("clr_vld", 64'(ov12), 64'd0);
        chk("clr_dout", dout12, 64'd0);
        chk("clr_rdy", 64'(rdy12), 64'd1);
        chk("clr_busy", 64'(busy12), 64'd0);
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (ov12 !== 1'b0) seen = 1;
        end
        chk("clr_no_output", 64'(seen), 64'd0);
        blk_a = {$urandom, $urandom};
        xfer(1'b1, 1'b0, blk_a, res);
        chk("clr_fresh", res, ref_enc(blk_a, 12));

        // Randomized keys, blocks and directions
        for (int t = 0; t < 12; t++) begin
            for (int k = 0; k < 26; k++) key_tab[k] = $urandom;
            pack_keys();
            blk_a = {$urandom, $urandom};
            m = 1'($urandom_range(0, 1));
            xfer(1'b1, m, blk_a, res);
            chk("rnd12", res, m ? ref_dec(blk_a, 12) : ref_enc(blk_a, 12));
            xfer(1'b1, ~m, res, res2);
            chk("rnd12_roundtrip", res2, blk_a);
            blk_b = {$urandom, $urandom};
            xfer(1'b0, m, blk_b, res);
            chk("rnd1", res, m ? ref_dec(blk_b, 1) : ref_enc(blk_b, 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rc5_crypt_core.md
RC5_CRYPT_CORE -- requirements
Module: rc5_crypt_core

Interface
REQ-001 SHALL have parameter W, default 32: word width in bits; legal values 16, 32, 64.
REQ-002 SHALL have parameter ROUNDS, default 12: round count; legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port clr, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port mode, input, 1 bit: 0 = encrypt, 1 = decrypt; sampled at accept.
REQ-006 SHALL have port di_vld, input, 1 bit: input block valid.
REQ-007 SHALL have port di_rdy, output, 1 bit: core can accept a block.
REQ-008 SHALL have port din, input, 2W bits: block, A = din[2W-1:W], B = din[W-1:0].
REQ-009 SHALL have port skey, input, (2*ROUNDS+2)*W bits: round key S[k] at bits [k*W +: W].
REQ-010 SHALL have port do_vld, output, 1 bit: result valid.
REQ-011 SHALL have port do_rdy, input, 1 bit: consumer takes the result.
REQ-012 SHALL have port dout, output, 2W bits: result {A,B}.
REQ-013 SHALL have port busy, output, 1 bit: high in the ROUND and DONE states.

Function
REQ-014 SHALL implement a state machine with states IDLE, ROUND and DONE; di_rdy is high only in IDLE.
REQ-015 SHALL accept a block on the edge where di_vld & di_rdy; this is the accept edge (edge k).
- mode is latched at the accept edge.
- The state moves to ROUND.
- The round counter i loads 1 for encrypt and ROUNDS for decrypt.
REQ-016 SHALL, at the accept edge in encrypt mode, register A = din_hi + S[0] and B = din_lo + S[1], both mod 2^W.
REQ-017 SHALL, at the accept edge in decrypt mode, register A = din_hi and B = din_lo unchanged.
REQ-018 SHALL, on each ROUND edge in encrypt mode, compute A' = ((A^B) <<< B[LGW-1:0]) + S[2i], then B' = ((B^A') <<< A'[LGW-1:0]) + S[2i+1], and increment i.
- LGW = log2(W).
REQ-019 SHALL, on each ROUND edge in decrypt mode, compute B' = ((B - S[2i+1]) >>> A[LGW-1:0]) ^ A, then A' = ((A - S[2i]) >>> B'[LGW-1:0]) ^ B', and decrement i.
REQ-020 SHALL, on the final decrypt round edge (i = 1), also subtract S[0] from A' and S[1] from B' before registering.
REQ-021 SHALL treat rotation by 0 as identity and perform all arithmetic mod 2^W.
REQ-022 SHALL execute exactly ROUNDS round edges: the last is at edge k+ROUNDS, after which the state is DONE and do_vld = 1.
REQ-023 SHALL hold dout and do_vld stable in DONE until do_rdy = 1.
- On that edge, the state returns to IDLE and do_vld clears.
- There is no accept on the same edge; di_rdy is high from the next cycle.
REQ-024 SHALL ignore di_vld while not in IDLE; blocks are not queued.
REQ-025 SHALL not latch skey; the source holds skey stable from the accept edge until the do_vld/do_rdy handshake.
REQ-026 SHALL make ROUNDS = 1 legal: DONE is reached at edge k+1.

Reset
REQ-027 SHALL, when clr = 1 at a rising edge, force: state IDLE; i = 0; A, B and dout all zero; do_vld = 0; busy = 0; latched mode = 0.
REQ-028 SHALL give clr priority over every other input, including mid-ROUND and in DONE; the block in flight is discarded with no output.
REQ-029 SHALL present di_rdy = 1 in the first cycle after clr deasserts.

Structure
REQ-030 SHALL place in the shared package: the state encoding (IDLE/ROUND/DONE), the P/Q magic constants for W = 16/32/64, and the clog2 helper.
REQ-031 SHALL implement the round datapath as one sub-module, rc5_round, with a mode input and W parameter, combinational, instantiated once.
- The core iterates this single rc5_round instance once per ROUNDS edge.
REQ-032 SHALL implement no key expansion; round keys come from the existing key-generation block.

Verification
REQ-033 W=32, ROUNDS=1, all S=0, encrypt din = 0x00000001_00000000 -> dout = 0x00000001_00000002 at edge k+1.
REQ-034 Same keys, decrypt din = 0x00000001_00000002 -> dout = 0x00000001_00000000.
REQ-035 W=32, ROUNDS=1, all S=0, encrypt din = 0x80000000_80000000 -> dout = 0x00000000_80000000 (checks rotate-by-0).
REQ-036 W=32, ROUNDS=12, S from key expansion of an all-zero 128-bit key, encrypt din = 0 -> dout = 0xEEDBA521_6D8F4B15 at edge k+12; decrypting that result returns 0.
REQ-037 Hold do_rdy = 0 for 5 cycles after do_vld rises, with di_vld held high -> dout stable, di_rdy = 0, no second accept; raise do_rdy -> IDLE, and the next accept is one cycle later.
REQ-038 Assert clr at edge k+6 of a 12-round encrypt -> do_vld never rises, dout = 0, di_rdy = 1 the next cycle, and a fresh block completes correctly.
